latency_monitor: RTL and testbench
==================================

LATENCY_MONITOR -- requirements
Module: latency_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of independent measurement channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the latency counter width per channel.
REQ-003 SHALL have parameter TIMEOUT, default 1000, the cycle limit; elaboration SHALL fail if TIMEOUT is 0 or greater than 2^CNT_WIDTH-1.
REQ-004 SHALL have port i_clk, input, 1 bit: clock; reset i_rst, synchronous, active-high; clock i_clk.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port i_start, input, NUM_CH bits: per-channel request-issued strobe.
REQ-007 SHALL have port i_done, input, NUM_CH bits: per-channel response-valid level; only its rising edge counts.
REQ-008 SHALL have port i_clear, input, 1 bit: clears the min/max statistics of all channels.
REQ-009 SHALL have port o_lat, output, NUM_CH*CNT_WIDTH bits: last latency per channel, with channel c at bits [c*CNT_WIDTH +: CNT_WIDTH].
REQ-010 SHALL have ports o_min and o_max, outputs, NUM_CH*CNT_WIDTH bits each: per-channel minimum and maximum latency, packed like o_lat.
REQ-011 SHALL have port o_valid, output, NUM_CH bits: one-cycle pulse per channel when that channel's o_lat updates.
REQ-012 SHALL have port o_timeout, output, NUM_CH bits: one-cycle pulse per channel on timeout.

Function
REQ-013 Each channel SHALL run an independent FSM with the states IDLE and RUN.
REQ-014 IDLE with i_start[c]=1 at edge k SHALL go to RUN with cnt=0; i_done is ignored at that edge, including when it is high simultaneously.
REQ-015 RUN without a done rising edge SHALL increment cnt by 1 per edge.
REQ-016 RUN with a done rising edge (i_done[c]=1 and the registered previous i_done[c]=0) SHALL store o_lat=cnt+1, pulse o_valid[c] in the following cycle, and go to IDLE.
REQ-017 Latency definition: start at cycle 0 and done first high at cycle N SHALL give o_lat=N; the minimum reportable value is 1.
REQ-018 RUN reaching cnt=TIMEOUT-1 without a done edge SHALL, at the next edge, pulse o_timeout[c], go to IDLE, and leave o_lat/o_min/o_max unchanged.
REQ-019 The counter SHALL never wrap, which follows from REQ-003.
REQ-020 i_start[c] in RUN SHALL be ignored and SHALL NOT restart the measurement.
REQ-021 A done rising edge in IDLE SHALL be ignored.
REQ-022 On each o_lat update: o_min SHALL take min(o_min, new) and o_max SHALL take max(o_max, new), in the same edge.
REQ-023 i_clear SHALL set o_min to all ones and o_max to 0 and SHALL leave FSM, cnt and o_lat untouched.
REQ-024 If i_clear and a completion occur in the same edge, o_min and o_max SHALL both take the new sample.
REQ-025 Channels SHALL NOT interact; simultaneous completions on several channels SHALL each pulse their own o_valid bit.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 i_rst SHALL force all FSMs to IDLE and set cnt=0, o_lat=0, o_max=0, o_min=all ones, o_valid=0, o_timeout=0, and the done-edge registers to 0.
REQ-028 Reset during RUN SHALL abandon the measurement with no o_valid or o_timeout pulse.
REQ-029 i_rst SHALL take priority over i_clear, i_start and i_done.

Configuration
REQ-030 With macro LATENCY_MONITOR_MINMAX_EN defined, min/max tracking SHALL be implemented per REQ-022..024.
REQ-031 Without LATENCY_MONITOR_MINMAX_EN, o_min and o_max SHALL be constant 0, i_clear SHALL be ignored, and no min/max registers SHALL exist.

Structure
REQ-032 Package latency_monitor_pkg SHALL hold the FSM state enum (ST_IDLE, ST_RUN) and a function that packs and unpacks channel slices.
REQ-033 Sub-module latency_monitor_ch SHALL implement one channel; the top level SHALL instantiate NUM_CH copies through generate and concatenate their outputs.

Verification
REQ-034 Verification SHALL cover: reset, start ch0 at cycle 0, done ch0 rising at cycle 5 -> o_lat[ch0]=5, o_valid[0] pulses once, o_min=o_max=5.
REQ-035 Verification SHALL cover: successive measurements of 3, 9, 6 on ch1 -> o_lat=6, o_min=3, o_max=9; then i_clear -> o_min=FFFF, o_max=0, o_lat=6.
REQ-036 Verification SHALL cover: TIMEOUT=10, start with no done -> o_timeout pulses 10 cycles after start, o_valid stays 0, o_lat is unchanged.
REQ-037 Verification SHALL cover: i_done held high before start, then start -> no completion until done falls and rises again; a second start in RUN does not reset cnt.
REQ-038 Verification SHALL cover: ch0 and ch3 completing in the same cycle with latencies 4 and 7 -> both o_valid bits pulse together with the correct per-channel values.
REQ-039 Verification SHALL cover: i_rst asserted at cnt=4 mid-RUN -> no pulses, outputs at reset values; rerun with the macro undefined -> o_min=o_max=0 always.

Source files
------------

// File: rtl/latency_monitor_pkg.sv
// Shared types and channel-slice helpers for the latency monitor.
// Pure declarations: no latency, no backpressure.
package latency_monitor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MAX_CH  = 16;
  localparam int MAX_CW  = 32;
  localparam int MAX_BUS = MAX_CH * MAX_CW;

  function automatic logic [MAX_CW-1:0] slice_mask(input int unsigned w);
    logic [MAX_CW-1:0] m;
    if (w >= MAX_CW) m = '1;
    else             m = (MAX_CW'(1) << w) - MAX_CW'(1);
    return m;
  endfunction

  // Extract channel c (width w) from a packed per-channel bus.
  function automatic logic [MAX_CW-1:0] slice_get(input logic [MAX_BUS-1:0] bus,
                                                  input int unsigned c,
                                                  input int unsigned w);
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (c * w);
    return sh[MAX_CW-1:0] & slice_mask(w);
  endfunction

  // Replace channel c (width w) of a packed per-channel bus with val.
  function automatic logic [MAX_BUS-1:0] slice_put(input logic [MAX_BUS-1:0] bus,
                                                   input int unsigned c,
                                                   input int unsigned w,
                                                   input logic [MAX_CW-1:0] val);
    logic [MAX_BUS-1:0] m;
    m = MAX_BUS'(slice_mask(w)) << (c * w);
    return (bus & ~m) | (MAX_BUS'(val & slice_mask(w)) << (c * w));
  endfunction

endpackage

// File: rtl/latency_monitor_if.sv
// Request/response strobes and latency results for NUM_CH channels.
// Signal bundle only: no latency, no backpressure.
interface latency_monitor_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16
);
  logic [NUM_CH-1:0]           start;
  logic [NUM_CH-1:0]           done;
  logic                        clear;
  logic [NUM_CH*CNT_WIDTH-1:0] lat;
  logic [NUM_CH*CNT_WIDTH-1:0] min_lat;
  logic [NUM_CH*CNT_WIDTH-1:0] max_lat;
  logic [NUM_CH-1:0]           valid;
  logic [NUM_CH-1:0]           timeout;

  modport master (
    output start, done, clear,
    input  lat, min_lat, max_lat, valid, timeout
  );

  modport slave (
    input  start, done, clear,
    output lat, min_lat, max_lat, valid, timeout
  );
endinterface

// File: rtl/latency_monitor_ch.sv
// One latency channel: start->done-rise cycle count, timeout, optional min/max (LATENCY_MONITOR_MINMAX_EN).
// Results registered one edge after the done edge; no backpressure, strobes are never stalled.
module latency_monitor_ch
  import latency_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input logic              i_clk,
  input logic              i_rst,
  latency_monitor_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] lat;
  logic                 done_q;
  logic                 valid;
  logic                 timeout;
  logic                 done_rise;
  logic [CNT_WIDTH-1:0] sample;

  assign done_rise = bus.done[0] & ~done_q;
  // cnt lags the cycle index by one, so the sample reported on the done edge is cnt+1
  assign sample    = cnt + CNT_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat     <= '0;
      done_q  <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done_q  <= bus.done[0];
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start[0]) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (done_rise) begin
            lat   <= sample;
            valid <= 1'b1;
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= sample;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.lat     = lat;
  assign bus.valid   = valid;
  assign bus.timeout = timeout;

`ifdef LATENCY_MONITOR_MINMAX_EN
  logic                 complete;
  logic [CNT_WIDTH-1:0] min_q;
  logic [CNT_WIDTH-1:0] max_q;

  assign complete = (state == ST_RUN) & done_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (complete) begin
      // a clear landing with a completion restarts the statistics at this sample
      if (bus.clear) begin
        min_q <= sample;
        max_q <= sample;
      end else begin
        if (sample < min_q) min_q <= sample;
        if (sample > max_q) max_q <= sample;
      end
    end else if (bus.clear) begin
      min_q <= '1;
      max_q <= '0;
    end
  end

  assign bus.min_lat = min_q;
  assign bus.max_lat = max_q;
`else
  logic unused_clear;
  assign unused_clear = bus.clear;
  assign bus.min_lat  = '0;
  assign bus.max_lat  = '0;
`endif

endmodule

// File: rtl/latency_monitor.sv
// NUM_CH independent request->response latency monitors; min/max tracking under LATENCY_MONITOR_MINMAX_EN.
// All outputs registered, one edge after the done edge; no backpressure.
module latency_monitor
  import latency_monitor_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CH-1:0]           i_start,
  input  logic [NUM_CH-1:0]           i_done,
  input  logic                        i_clear,
  output logic [NUM_CH*CNT_WIDTH-1:0] o_lat,
  output logic [NUM_CH*CNT_WIDTH-1:0] o_min,
  output logic [NUM_CH*CNT_WIDTH-1:0] o_max,
  output logic [NUM_CH-1:0]           o_valid,
  output logic [NUM_CH-1:0]           o_timeout
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;
  localparam bit TIMEOUT_OK = (TIMEOUT >= 1) && (64'(TIMEOUT) <= CNT_MAX);
  localparam bit GEOM_OK    = (NUM_CH >= 1) && (NUM_CH <= MAX_CH) &&
                              (CNT_WIDTH >= 1) && (CNT_WIDTH <= MAX_CW);

  if (!TIMEOUT_OK) begin : g_bad_timeout
    $error("latency_monitor: TIMEOUT must be in 1..2^CNT_WIDTH-1");
  end
  if (!GEOM_OK) begin : g_bad_geom
    $error("latency_monitor: NUM_CH must be 1..16 and CNT_WIDTH 1..32");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    latency_monitor_if #(.NUM_CH(1), .CNT_WIDTH(CNT_WIDTH)) ch_if ();

    assign ch_if.start = i_start[c];
    assign ch_if.done  = i_done[c];
    assign ch_if.clear = i_clear;

    latency_monitor_ch #(
      .CNT_WIDTH (CNT_WIDTH),
      .TIMEOUT   (TIMEOUT)
    ) u_ch (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (ch_if.slave)
    );

    assign o_lat[c*CNT_WIDTH +: CNT_WIDTH] = ch_if.lat;
    assign o_min[c*CNT_WIDTH +: CNT_WIDTH] = ch_if.min_lat;
    assign o_max[c*CNT_WIDTH +: CNT_WIDTH] = ch_if.max_lat;
    assign o_valid[c]                      = ch_if.valid[0];
    assign o_timeout[c]                    = ch_if.timeout[0];
  end

endmodule

// File: tb/tb_latency_monitor.sv
// Directed checks of latency_monitor (NUM_CH=4, CNT_WIDTH=16, TIMEOUT=10).
// Expectations for o_min/o_max follow LATENCY_MONITOR_MINMAX_EN.
module tb_latency_monitor;
  import latency_monitor_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int TO  = 10;
`ifdef LATENCY_MONITOR_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  latency_monitor_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) mon_if ();

  latency_monitor #(
    .NUM_CH    (NCH),
    .CNT_WIDTH (CW),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (mon_if.start),
    .i_done    (mon_if.done),
    .i_clear   (mon_if.clear),
    .o_lat     (mon_if.lat),
    .o_min     (mon_if.min_lat),
    .o_max     (mon_if.max_lat),
    .o_valid   (mon_if.valid),
    .o_timeout (mon_if.timeout)
  );

  function automatic logic [CW-1:0] ch_val(input logic [NCH*CW-1:0] v, input int c);
    logic [MAX_CW-1:0] s;
    s = slice_get(MAX_BUS'(v), c, CW);
    return s[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] exp_mm(input logic [CW-1:0] v);
    return MINMAX ? v : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start at edge E0, done rises at edge En; returns just after En with done still high
  task automatic measure(input int c, input int n);
    mon_if.start[c] = 1'b1;
    tick();
    mon_if.start[c] = 1'b0;
    repeat (n - 1) tick();
    mon_if.done[c] = 1'b1;
    tick();
  endtask

  task automatic drop_done(input int c);
    mon_if.done[c] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (mon_if.lat !== '0) begin
      n_fail++; $display("FAIL reset_lat: got %h expected 0", mon_if.lat);
    end
    n_checks++;
    if (mon_if.valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0000", mon_if.valid);
    end
    n_checks++;
    if (mon_if.timeout !== 4'b0000) begin
      n_fail++; $display("FAIL reset_timeout: got %b expected 0000", mon_if.timeout);
    end
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (ch_val(mon_if.min_lat, c) !== exp_mm(16'hFFFF)) begin
        n_fail++; $display("FAIL reset_min ch%0d: got %h expected %h", c, ch_val(mon_if.min_lat, c), exp_mm(16'hFFFF));
      end
      n_checks++;
      if (ch_val(mon_if.max_lat, c) !== 16'h0000) begin
        n_fail++; $display("FAIL reset_max ch%0d: got %h expected 0000", c, ch_val(mon_if.max_lat, c));
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    measure(0, 5);
    n_checks++;
    if (mon_if.valid !== 4'b0001) begin
      n_fail++; $display("FAIL basic_valid: got %b expected 0001", mon_if.valid);
    end
    n_checks++;
    if (ch_val(mon_if.lat, 0) !== 16'd5) begin
      n_fail++; $display("FAIL basic_lat: got %0d expected 5", ch_val(mon_if.lat, 0));
    end
    n_checks++;
    if (ch_val(mon_if.min_lat, 0) !== exp_mm(16'd5)) begin
      n_fail++; $display("FAIL basic_min: got %0d expected %0d", ch_val(mon_if.min_lat, 0), exp_mm(16'd5));
    end
    n_checks++;
    if (ch_val(mon_if.max_lat, 0) !== exp_mm(16'd5)) begin
      n_fail++; $display("FAIL basic_max: got %0d expected %0d", ch_val(mon_if.max_lat, 0), exp_mm(16'd5));
    end
    drop_done(0);
    n_checks++;
    if (mon_if.valid !== 4'b0000) begin
      n_fail++; $display("FAIL basic_single_pulse: got %b expected 0000", mon_if.valid);
    end
  endtask

  task automatic test_stats();
    measure(1, 3);
    n_checks++;
    if (ch_val(mon_if.lat, 1) !== 16'd3) begin
      n_fail++; $display("FAIL stats_lat3: got %0d expected 3", ch_val(mon_if.lat, 1));
    end
    drop_done(1);
    measure(1, 9);
    n_checks++;
    if (ch_val(mon_if.lat, 1) !== 16'd9) begin
      n_fail++; $display("FAIL stats_lat9: got %0d expected 9", ch_val(mon_if.lat, 1));
    end
    drop_done(1);
    measure(1, 6);
    n_checks++;
    if (ch_val(mon_if.lat, 1) !== 16'd6) begin
      n_fail++; $display("FAIL stats_lat6: got %0d expected 6", ch_val(mon_if.lat, 1));
    end
    n_checks++;
    if (ch_val(mon_if.min_lat, 1) !== exp_mm(16'd3)) begin
      n_fail++; $display("FAIL stats_min: got %0d expected %0d", ch_val(mon_if.min_lat, 1), exp_mm(16'd3));
    end
    n_checks++;
    if (ch_val(mon_if.max_lat, 1) !== exp_mm(16'd9)) begin
      n_fail++; $display("FAIL stats_max: got %0d expected %0d", ch_val(mon_if.max_lat, 1), exp_mm(16'd9));
    end
    drop_done(1);

    mon_if.clear = 1'b1;
    tick();
    mon_if.clear = 1'b0;
    n_checks++;
    if (ch_val(mon_if.min_lat, 1) !== exp_mm(16'hFFFF)) begin
      n_fail++; $display("FAIL clear_min: got %h expected %h", ch_val(mon_if.min_lat, 1), exp_mm(16'hFFFF));
    end
    n_checks++;
    if (ch_val(mon_if.max_lat, 1) !== 16'h0000) begin
      n_fail++; $display("FAIL clear_max: got %h expected 0000", ch_val(mon_if.max_lat, 1));
    end
    n_checks++;
    if (ch_val(mon_if.lat, 1) !== 16'd6) begin
      n_fail++; $display("FAIL clear_keeps_lat: got %0d expected 6", ch_val(mon_if.lat, 1));
    end

    // clear on the same edge as a completion of latency 4
    mon_if.start[1] = 1'b1;
    tick();
    mon_if.start[1] = 1'b0;
    repeat (3) tick();
    mon_if.done[1] = 1'b1;
    mon_if.clear   = 1'b1;
    tick();
    mon_if.clear   = 1'b0;
    n_checks++;
    if (mon_if.valid !== 4'b0010 || ch_val(mon_if.lat, 1) !== 16'd4) begin
      n_fail++; $display("FAIL clear_cmpl_lat: got valid %b lat %0d expected 0010 4", mon_if.valid, ch_val(mon_if.lat, 1));
    end
    n_checks++;
    if (ch_val(mon_if.min_lat, 1) !== exp_mm(16'd4) || ch_val(mon_if.max_lat, 1) !== exp_mm(16'd4)) begin
      n_fail++; $display("FAIL clear_cmpl_minmax: got %0d/%0d expected %0d/%0d", ch_val(mon_if.min_lat, 1), ch_val(mon_if.max_lat, 1), exp_mm(16'd4), exp_mm(16'd4));
    end
    drop_done(1);
  endtask

  task automatic test_timeout();
    mon_if.start[2] = 1'b1;
    tick();
    mon_if.start[2] = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      n_checks++;
      if (mon_if.timeout !== 4'b0000) begin
        n_fail++; $display("FAIL timeout_early cycle %0d: got %b expected 0000", i, mon_if.timeout);
      end
    end
    tick();
    n_checks++;
    if (mon_if.timeout !== 4'b0100) begin
      n_fail++; $display("FAIL timeout_pulse: got %b expected 0100", mon_if.timeout);
    end
    n_checks++;
    if (mon_if.valid !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_valid: got %b expected 0000", mon_if.valid);
    end
    n_checks++;
    if (ch_val(mon_if.lat, 2) !== 16'd0 || ch_val(mon_if.max_lat, 2) !== 16'd0) begin
      n_fail++; $display("FAIL timeout_lat: got lat %0d max %0d expected 0 0", ch_val(mon_if.lat, 2), ch_val(mon_if.max_lat, 2));
    end
    tick();
    n_checks++;
    if (mon_if.timeout !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_single_pulse: got %b expected 0000", mon_if.timeout);
    end
    mon_if.done[2] = 1'b1;
    tick();
    n_checks++;
    if (mon_if.valid !== 4'b0000) begin
      n_fail++; $display("FAIL idle_done_ignored: got %b expected 0000", mon_if.valid);
    end
    drop_done(2);
  endtask

  task automatic test_done_held();
    mon_if.done[3] = 1'b1;
    tick();
    tick();
    mon_if.start[3] = 1'b1;
    tick();
    mon_if.start[3] = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++;
      if (mon_if.valid !== 4'b0000) begin
        n_fail++; $display("FAIL held_done_no_cmpl cycle %0d: got %b expected 0000", i, mon_if.valid);
      end
    end
    mon_if.done[3] = 1'b0;
    tick();
    mon_if.start[3] = 1'b1;
    tick();
    mon_if.start[3] = 1'b0;
    mon_if.done[3]  = 1'b1;
    tick();
    n_checks++;
    if (mon_if.valid !== 4'b1000) begin
      n_fail++; $display("FAIL held_done_valid: got %b expected 1000", mon_if.valid);
    end
    n_checks++;
    if (ch_val(mon_if.lat, 3) !== 16'd5) begin
      n_fail++; $display("FAIL restart_ignored_lat: got %0d expected 5", ch_val(mon_if.lat, 3));
    end
    drop_done(3);
  endtask

  task automatic test_back_to_back();
    mon_if.start = 4'b1000;
    tick();
    mon_if.start = 4'b0000;
    repeat (2) tick();
    mon_if.start = 4'b0001;
    tick();
    mon_if.start = 4'b0000;
    repeat (3) tick();
    mon_if.done = 4'b1001;
    tick();
    n_checks++;
    if (mon_if.valid !== 4'b1001) begin
      n_fail++; $display("FAIL b2b_valid: got %b expected 1001", mon_if.valid);
    end
    n_checks++;
    if (ch_val(mon_if.lat, 0) !== 16'd4 || ch_val(mon_if.lat, 3) !== 16'd7) begin
      n_fail++; $display("FAIL b2b_lat: got %0d/%0d expected 4/7", ch_val(mon_if.lat, 0), ch_val(mon_if.lat, 3));
    end
    n_checks++;
    if (ch_val(mon_if.lat, 1) !== 16'd4 || ch_val(mon_if.lat, 2) !== 16'd0) begin
      n_fail++; $display("FAIL b2b_isolation: got %0d/%0d expected 4/0", ch_val(mon_if.lat, 1), ch_val(mon_if.lat, 2));
    end
    n_checks++;
    if (ch_val(mon_if.min_lat, 0) !== exp_mm(16'd4) || ch_val(mon_if.max_lat, 0) !== exp_mm(16'd4)) begin
      n_fail++; $display("FAIL b2b_minmax_ch0: got %0d/%0d expected %0d/%0d", ch_val(mon_if.min_lat, 0), ch_val(mon_if.max_lat, 0), exp_mm(16'd4), exp_mm(16'd4));
    end
    n_checks++;
    if (ch_val(mon_if.min_lat, 3) !== exp_mm(16'd5) || ch_val(mon_if.max_lat, 3) !== exp_mm(16'd7)) begin
      n_fail++; $display("FAIL b2b_minmax_ch3: got %0d/%0d expected %0d/%0d", ch_val(mon_if.min_lat, 3), ch_val(mon_if.max_lat, 3), exp_mm(16'd5), exp_mm(16'd7));
    end
    mon_if.done = 4'b0000;
    tick();
    n_checks++;
    if (mon_if.valid !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_single_pulse: got %b expected 0000", mon_if.valid);
    end
  endtask

  task automatic test_reset_mid_run();
    mon_if.start[2] = 1'b1;
    tick();
    mon_if.start[2] = 1'b0;
    repeat (4) tick();
    // reset must win over simultaneous start, done and clear
    rst             = 1'b1;
    mon_if.start[1] = 1'b1;
    mon_if.done[0]  = 1'b1;
    mon_if.clear    = 1'b1;
    tick();
    rst             = 1'b0;
    mon_if.start[1] = 1'b0;
    mon_if.done[0]  = 1'b0;
    mon_if.clear    = 1'b0;
    n_checks++;
    if (mon_if.lat !== '0 || mon_if.valid !== 4'b0000 || mon_if.timeout !== 4'b0000) begin
      n_fail++; $display("FAIL midrun_reset: got lat %h valid %b timeout %b expected 0", mon_if.lat, mon_if.valid, mon_if.timeout);
    end
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (ch_val(mon_if.min_lat, c) !== exp_mm(16'hFFFF) || ch_val(mon_if.max_lat, c) !== 16'h0000) begin
        n_fail++; $display("FAIL midrun_minmax ch%0d: got %h/%h expected %h/0000", c, ch_val(mon_if.min_lat, c), ch_val(mon_if.max_lat, c), exp_mm(16'hFFFF));
      end
    end
    for (int i = 0; i < TO + 2; i++) begin
      tick();
      n_checks++;
      if (mon_if.timeout !== 4'b0000 || mon_if.valid !== 4'b0000) begin
        n_fail++; $display("FAIL midrun_no_pulse cycle %0d: got timeout %b valid %b expected 0000", i, mon_if.timeout, mon_if.valid);
      end
    end
    mon_if.done[2] = 1'b1;
    tick();
    n_checks++;
    if (mon_if.valid !== 4'b0000) begin
      n_fail++; $display("FAIL midrun_abandoned: got %b expected 0000", mon_if.valid);
    end
    drop_done(2);
  endtask

  initial begin
    rst          = 1'b1;
    mon_if.start = '0;
    mon_if.done  = '0;
    mon_if.clear = 1'b0;
    test_reset();
    test_basic();
    test_stats();
    test_timeout();
    test_done_held();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
